// File: rtl/snake_pkg.sv
// snake_pkg: shared tick-generator state encoding, default timing constants and tick counter width
package snake_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PAUSED, ST_STEP} tick_state_t;
  localparam int DEF_BASE_PERIOD = 4194302;
  localparam int DEF_STEP = 262144;
  localparam int DEF_MIN_PERIOD = 1048576;
  localparam int DEF_LEAD = 1;
  localparam int TICK_CNT_W = 16;
endpackage

// File: rtl/game_tick_gen_if.sv
// game_tick_gen_if: control inputs (pause, step, speed_up, speed_reset) and outputs (tick, pre_tick, level, paused, tick_count); master drives controls, slave is the generator
interface game_tick_gen_if
  import snake_pkg::*;
#(
  parameter int LEVEL_W = 3
);
  logic pause, step, speed_up, speed_reset;
  logic tick, pre_tick, paused;
  logic [LEVEL_W-1:0] level;
  logic [TICK_CNT_W-1:0] tick_count;
  modport master (
    output pause, step, speed_up, speed_reset,
    input tick, pre_tick, paused, level, tick_count
  );
  modport slave (
    input pause, step, speed_up, speed_reset,
    output tick, pre_tick, paused, level, tick_count
  );
endinterface

// File: rtl/tick_period_lut.sv
// tick_period_lut: level -> max(BASE_PERIOD - level*STEP, MIN_PERIOD); in level, out period
module tick_period_lut #(
  parameter int CNT_W = 22,
  parameter int LEVEL_W = 3,
  parameter int BASE_PERIOD = 4194302,
  parameter int STEP = 262144,
  parameter int MIN_PERIOD = 1048576
) (
  input  logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   period
);
  localparam int W = CNT_W + LEVEL_W;
  logic [W-1:0] red, diff;
  assign red = W'(level) * W'(STEP);
  assign diff = W'(BASE_PERIOD) - red;
  assign period = (red > W'(BASE_PERIOD) || diff < W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : diff[CNT_W-1:0];
endmodule

// File: rtl/game_tick_gen.sv
// game_tick_gen: game-step tick and lead pre_tick generator with speed levels, pause and single-step; ports clk, reset, bus (game_tick_gen_if.slave)
module game_tick_gen
  import snake_pkg::*;
#(
  parameter int CNT_W = 22,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP = DEF_STEP,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int NUM_LEVELS = 8,
  parameter int LEVEL_W = 3,
  parameter int LEAD = DEF_LEAD
) (
  input logic clk,
  input logic reset,
  game_tick_gen_if.slave bus
);
  tick_state_t state;
  logic [CNT_W-1:0] cnt, period, lut_period, last, pre_at;
  logic [LEVEL_W-1:0] level, pend_level;
  logic [TICK_CNT_W-1:0] tick_count;
  logic tick, pre_tick, paused, wrap;
  tick_period_lut #(
    .CNT_W(CNT_W), .LEVEL_W(LEVEL_W), .BASE_PERIOD(BASE_PERIOD), .STEP(STEP), .MIN_PERIOD(MIN_PERIOD)
  ) lut (
    .level(pend_level),
    .period(lut_period)
  );
  assign last = period - CNT_W'(1);
  assign pre_at = last - CNT_W'(LEAD);
  assign wrap = cnt == last;
  assign bus.tick = tick;
  assign bus.pre_tick = pre_tick;
  assign bus.paused = paused;
  assign bus.level = level;
  assign bus.tick_count = tick_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt <= '0;
      tick <= 1'b0;
      pre_tick <= 1'b0;
      paused <= 1'b0;
      level <= '0;
      pend_level <= '0;
      period <= CNT_W'(BASE_PERIOD);
      tick_count <= '0;
    end else begin
      tick <= 1'b0;
      pre_tick <= 1'b0;
      pend_level <= bus.speed_reset ? '0 :
                    (bus.speed_up && pend_level < LEVEL_W'(NUM_LEVELS - 1)) ? pend_level + LEVEL_W'(1) : pend_level;
      if (state == ST_PAUSED) begin
        if (!bus.pause) begin
          state <= ST_RUN;
          paused <= 1'b0;
        end else if (bus.step) begin
          // jump straight to the post-pre_tick position so tick lands LEAD cycles later
          state <= ST_STEP;
          paused <= 1'b0;
          pre_tick <= 1'b1;
          cnt <= period - CNT_W'(LEAD);
        end
      end else if (state == ST_RUN && bus.pause && cnt <= pre_at) begin
        state <= ST_PAUSED;
        paused <= 1'b1;
      end else begin
        // RUN, DRAIN and STEP all count; DRAIN/STEP only leave on the tick so a pair is never split
        pre_tick <= cnt == pre_at;
        tick <= wrap;
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
        if (wrap) begin
          level <= pend_level;
          period <= lut_period;
          tick_count <= tick_count + TICK_CNT_W'(1);
          state <= bus.pause ? ST_PAUSED : ST_RUN;
          paused <= bus.pause;
        end else if (bus.pause && state == ST_RUN) begin
          state <= ST_DRAIN;
        end
      end
    end
  end
endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: scoreboard bench for game_tick_gen with BASE_PERIOD=10, STEP=2, MIN_PERIOD=4, NUM_LEVELS=5, LEAD=1
module tb_game_tick_gen;
  import snake_pkg::*;
  localparam int LEAD = 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int tq[$];
  int pq[$];
  game_tick_gen_if #(.LEVEL_W(3)) bus ();
  game_tick_gen #(
    .CNT_W(8), .BASE_PERIOD(10), .STEP(2), .MIN_PERIOD(4), .NUM_LEVELS(5), .LEVEL_W(3), .LEAD(LEAD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end
  always begin
    @(posedge clk);
    #1;
    if (reset) cyc = 0;
    else begin
      cyc++;
      if (tq.size() != 0 && tq[0] <= cyc) begin
        checks++;
        if (bus.tick !== 1'b1) begin
          errors++;
          $display("FAIL tick_expected cycle=%0d got=%b want=1", cyc, bus.tick);
        end
        tq.delete(0);
      end else if (bus.tick !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL tick_unexpected cycle=%0d got=%b want=0", cyc, bus.tick);
      end
      if (pq.size() != 0 && pq[0] <= cyc) begin
        checks++;
        if (bus.pre_tick !== 1'b1) begin
          errors++;
          $display("FAIL pre_tick_expected cycle=%0d got=%b want=1", cyc, bus.pre_tick);
        end
        pq.delete(0);
      end else if (bus.pre_tick !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL pre_tick_unexpected cycle=%0d got=%b want=0", cyc, bus.pre_tick);
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.pause = 1'b0;
    bus.step = 1'b0;
    bus.speed_up = 1'b0;
    bus.speed_reset = 1'b0;
    tq.delete();
    pq.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic expect_pair(input int t);
    tq.push_back(t);
    pq.push_back(t - LEAD);
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.tick !== 1'b0 || bus.pre_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got=%b%b want=00", bus.pre_tick, bus.tick);
    end
    checks++;
    if (bus.paused !== 1'b0) begin
      errors++;
      $display("FAIL reset_paused got=%b want=0", bus.paused);
    end
    checks++;
    if (bus.level !== 3'd0) begin
      errors++;
      $display("FAIL reset_level got=%0d want=0", bus.level);
    end
    checks++;
    if (bus.tick_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_tick_count got=%0d want=0", bus.tick_count);
    end
  endtask
  task automatic test_free_run();
    do_reset();
    for (int i = 1; i <= 4; i++) expect_pair(10 * i);
    wait_to(40);
    checks++;
    if (bus.tick_count !== 16'd4) begin
      errors++;
      $display("FAIL free_run_count got=%0d want=4", bus.tick_count);
    end
    checks++;
    if (bus.level !== 3'd0) begin
      errors++;
      $display("FAIL free_run_level got=%0d want=0", bus.level);
    end
    checks++;
    if (tq.size() + pq.size() != 0) begin
      errors++;
      $display("FAIL free_run_pending got=%0d want=0", tq.size() + pq.size());
    end
  endtask
  task automatic test_speed();
    do_reset();
    expect_pair(10);
    expect_pair(16);
    expect_pair(20);
    expect_pair(24);
    wait_to(3);
    bus.speed_up = 1'b1;
    wait_to(4);
    bus.speed_up = 1'b0;
    wait_to(5);
    bus.speed_up = 1'b1;
    wait_to(6);
    bus.speed_up = 1'b0;
    wait_to(9);
    checks++;
    if (bus.level !== 3'd0) begin
      errors++;
      $display("FAIL speed_level_before got=%0d want=0", bus.level);
    end
    wait_to(10);
    checks++;
    if (bus.level !== 3'd2) begin
      errors++;
      $display("FAIL speed_level_applied got=%0d want=2", bus.level);
    end
    wait_to(11);
    bus.speed_up = 1'b1;
    wait_to(15);
    bus.speed_up = 1'b0;
    wait_to(16);
    checks++;
    if (bus.level !== 3'd4) begin
      errors++;
      $display("FAIL speed_level_saturate got=%0d want=4", bus.level);
    end
    wait_to(24);
    checks++;
    if (bus.tick_count !== 16'd4) begin
      errors++;
      $display("FAIL speed_count got=%0d want=4", bus.tick_count);
    end
    checks++;
    if (tq.size() + pq.size() != 0) begin
      errors++;
      $display("FAIL speed_pending got=%0d want=0", tq.size() + pq.size());
    end
  endtask
  task automatic test_pause();
    do_reset();
    expect_pair(31);
    wait_to(4);
    bus.pause = 1'b1;
    wait_to(5);
    checks++;
    if (bus.paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_entered got=%b want=1", bus.paused);
    end
    wait_to(24);
    checks++;
    if (bus.paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_held got=%b want=1", bus.paused);
    end
    bus.pause = 1'b0;
    wait_to(25);
    checks++;
    if (bus.paused !== 1'b0) begin
      errors++;
      $display("FAIL pause_resumed got=%b want=0", bus.paused);
    end
    wait_to(31);
    checks++;
    if (bus.tick_count !== 16'd1) begin
      errors++;
      $display("FAIL pause_count got=%0d want=1", bus.tick_count);
    end
    checks++;
    if (tq.size() + pq.size() != 0) begin
      errors++;
      $display("FAIL pause_pending got=%0d want=0", tq.size() + pq.size());
    end
  endtask
  task automatic test_drain();
    do_reset();
    expect_pair(10);
    wait_to(9);
    bus.pause = 1'b1;
    wait_to(11);
    checks++;
    if (bus.paused !== 1'b1) begin
      errors++;
      $display("FAIL drain_paused got=%b want=1", bus.paused);
    end
    wait_to(15);
    bus.pause = 1'b0;
    expect_pair(26);
    wait_to(16);
    checks++;
    if (bus.paused !== 1'b0) begin
      errors++;
      $display("FAIL drain_resumed got=%b want=0", bus.paused);
    end
    wait_to(26);
    checks++;
    if (bus.tick_count !== 16'd2) begin
      errors++;
      $display("FAIL drain_count got=%0d want=2", bus.tick_count);
    end
    checks++;
    if (tq.size() + pq.size() != 0) begin
      errors++;
      $display("FAIL drain_pending got=%0d want=0", tq.size() + pq.size());
    end
  endtask
  task automatic test_step();
    do_reset();
    expect_pair(8);
    wait_to(2);
    bus.pause = 1'b1;
    wait_to(3);
    checks++;
    if (bus.paused !== 1'b1) begin
      errors++;
      $display("FAIL step_paused got=%b want=1", bus.paused);
    end
    wait_to(6);
    bus.step = 1'b1;
    wait_to(7);
    bus.step = 1'b0;
    checks++;
    if (bus.paused !== 1'b0) begin
      errors++;
      $display("FAIL step_state_paused got=%b want=0", bus.paused);
    end
    wait_to(9);
    checks++;
    if (bus.paused !== 1'b1) begin
      errors++;
      $display("FAIL step_back_paused got=%b want=1", bus.paused);
    end
    wait_to(12);
    bus.pause = 1'b0;
    expect_pair(23);
    wait_to(15);
    bus.step = 1'b1;
    wait_to(16);
    bus.step = 1'b0;
    wait_to(23);
    checks++;
    if (bus.tick_count !== 16'd2) begin
      errors++;
      $display("FAIL step_count got=%0d want=2", bus.tick_count);
    end
    checks++;
    if (tq.size() + pq.size() != 0) begin
      errors++;
      $display("FAIL step_pending got=%0d want=0", tq.size() + pq.size());
    end
  endtask
  task automatic test_speed_reset();
    do_reset();
    expect_pair(10);
    expect_pair(14);
    expect_pair(24);
    wait_to(1);
    bus.speed_up = 1'b1;
    wait_to(4);
    bus.speed_up = 1'b0;
    wait_to(10);
    checks++;
    if (bus.level !== 3'd3) begin
      errors++;
      $display("FAIL sreset_level3 got=%0d want=3", bus.level);
    end
    wait_to(11);
    bus.speed_up = 1'b1;
    bus.speed_reset = 1'b1;
    wait_to(12);
    bus.speed_up = 1'b0;
    bus.speed_reset = 1'b0;
    wait_to(14);
    checks++;
    if (bus.level !== 3'd0) begin
      errors++;
      $display("FAIL sreset_level0 got=%0d want=0", bus.level);
    end
    wait_to(15);
    bus.speed_up = 1'b1;
    wait_to(16);
    bus.speed_up = 1'b0;
    wait_to(24);
    checks++;
    if (bus.level !== 3'd1 || bus.tick_count !== 16'd3) begin
      errors++;
      $display("FAIL sreset_level1 got=%0d/%0d want=1/3", bus.level, bus.tick_count);
    end
    checks++;
    if (tq.size() + pq.size() != 0) begin
      errors++;
      $display("FAIL sreset_pending got=%0d want=0", tq.size() + pq.size());
    end
    wait_to(28);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.tick, bus.pre_tick, bus.paused} !== 3'b000 || bus.level !== 3'd0 || bus.tick_count !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b%b%b/%0d/%0d want=000/0/0", bus.tick, bus.pre_tick, bus.paused, bus.level, bus.tick_count);
    end
    reset = 1'b0;
    expect_pair(10);
    wait_to(10);
    checks++;
    if (bus.level !== 3'd0 || bus.tick_count !== 16'd1) begin
      errors++;
      $display("FAIL midreset_first_tick got=%0d/%0d want=0/1", bus.level, bus.tick_count);
    end
    checks++;
    if (tq.size() + pq.size() != 0) begin
      errors++;
      $display("FAIL midreset_pending got=%0d want=0", tq.size() + pq.size());
    end
  endtask
  initial begin
    bus.pause = 1'b0;
    bus.step = 1'b0;
    bus.speed_up = 1'b0;
    bus.speed_reset = 1'b0;
    test_reset();
    test_free_run();
    test_speed();
    test_pause();
    test_drain();
    test_step();
    test_speed_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/game_tick_gen.md
Name: game_tick_gen

Overview:
- Parametrised successor to the top-level slow-clock divider.
- Produces a single-cycle game-step enable `tick` in the `clk` domain instead of a derived clock. It also produces a `pre_tick` pulse LEAD cycles earlier, used to clear the board memory before the snake logic steps.
- Adds runtime speed levels, pause and single-step.
- Sits between the top level and the snake logic, board memory and score logic.

Parameters:
- CNT_W, 22: period counter width.
- BASE_PERIOD, 4194302: clk cycles per tick at level 0.
- STEP, 262144: period reduction per speed level.
- MIN_PERIOD, 1048576: lower clamp on the period.
- NUM_LEVELS, 8: number of speed levels.
- LEVEL_W, 3: width of `level`; must satisfy 2^LEVEL_W >= NUM_LEVELS.
- LEAD, 1: cycles between `pre_tick` and `tick`; legal range 1 <= LEAD <= MIN_PERIOD-2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- pause, input, 1: level; hold game time while high.
- step, input, 1: one-cycle pulse; request one tick while paused.
- speed_up, input, 1: one-cycle pulse; raise the speed level by one.
- speed_reset, input, 1: one-cycle pulse; return to level 0.
- tick, output, 1: one-cycle game-step enable.
- pre_tick, output, 1: one-cycle clear strobe, LEAD cycles before `tick`.
- level, output, LEVEL_W: currently applied speed level.
- paused, output, 1: high in the PAUSED state.
- tick_count, output, 16: number of ticks issued; wraps.

Behaviour:
- Reset (synchronous, active-high, at clk posedge):
  - cnt=0, state=RUN.
  - tick=0, pre_tick=0, paused=0.
  - level=0, pend_level=0, period=BASE_PERIOD, tick_count=0.
  - Reset wins over every other input.
- Period rule: period(L) = max(BASE_PERIOD - L*STEP, MIN_PERIOD).
  - Compute it in CNT_W+LEVEL_W bits, then clamp.
  - Register it; no combinational multiply in the count path.
- Counter:
  - cnt runs 0..period-1, then wraps to 0.
  - pre_tick is the registered decode of cnt==period-1-LEAD.
  - tick is the registered decode of cnt==period-1.
  - After reset release, the first pre_tick is high exactly BASE_PERIOD-LEAD cycles after the release edge. The first tick is high exactly BASE_PERIOD cycles after it.
  - Every tick is preceded by exactly one pre_tick, LEAD cycles earlier.
- FSM states: RUN, DRAIN, PAUSED, STEP.
  - RUN, pause=1, cnt <= period-1-LEAD (no pre_tick issued yet this period): go to PAUSED; cnt holds.
  - RUN, pause=1, pre_tick already issued this period: go to DRAIN. Counting continues until the pending tick is issued, then go to PAUSED with cnt=0. A pre_tick/tick pair is never split.
  - PAUSED, pause=0: go to RUN; counting resumes from the held cnt.
  - PAUSED, step=1 (pause still high): go to STEP and issue pre_tick next cycle. tick follows LEAD cycles later, then return to PAUSED with cnt=0.
  - step in any state other than PAUSED is ignored.
  - pause dropping during STEP or DRAIN: finish the pair, then go to RUN with cnt=0.
  - paused=1 only in the PAUSED state.
- Speed:
  - speed_up: pend_level = min(pend_level+1, NUM_LEVELS-1). Accepted in any state; several pulses in one period accumulate.
  - speed_reset: pend_level=0. Same cycle as speed_up: speed_reset wins.
  - pend_level is copied to level, and period is recomputed, only on the cycle cnt wraps to 0 (after a tick). Never mid-period, so pre_tick/tick spacing is always consistent.
- tick_count: increments on every tick cycle; wraps 0xFFFF -> 0.

Decomposition:
- Package snake_pkg holds:
  - the state encoding typedef (RUN, DRAIN, PAUSED, STEP);
  - default timing constants (BASE_PERIOD, STEP, MIN_PERIOD, LEAD);
  - the TICK_CNT_W=16 constant.
- Sub-module tick_period_lut: combinational level -> clamped period. It is reused later by the score/HUD block to display speed.
- FSM and counter stay in game_tick_gen.

Test Plan:
All scenarios use BASE_PERIOD=10, STEP=2, MIN_PERIOD=4, NUM_LEVELS=5, LEAD=1.
1. Release reset, free run 40 cycles -> pre_tick at cycles 9, 19, 29, 39; tick at 10, 20, 30, 40; tick_count=4; level=0.
2. speed_up at cycle 3 and cycle 5 -> level stays 0 until the tick at cycle 10, then level=2. Next tick at 16 (period 6); four more speed_up pulses -> level saturates at 4, period clamps to 4.
3. pause raised at cycle 4, held 20 cycles, dropped -> no pulses while paused=1; next tick exactly 6 cycles after RUN resumes.
4. pause raised on the cycle pre_tick is high -> DRAIN; tick still issues 1 cycle later, then paused=1 with cnt=0.
5. In PAUSED, step pulse -> pre_tick next cycle, tick the cycle after, back to PAUSED. step during RUN -> no extra pulse.
6. speed_up and speed_reset in the same cycle at level 3 -> level=0 after the next tick. reset asserted mid-period -> all outputs zero the next cycle, and the first tick is 10 cycles after release.
